// File: rtl/load_store_unit.sv
// load_store_unit: single-request initiator for the 32 x 32-bit data memory.
// Loads return little-endian lane data extended to 32 bits; sub-word stores
// are done as read-modify-write because the memory only writes whole words.
// Optional feature macro: LSU_SUBWORD_EN enables byte/halfword accesses.
// Without it only aligned word accesses are legal; other sizes respond with
// rsp_err and never touch memory.
module load_store_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [6:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        data_read_flag,
   output logic        data_write_flag,
   output logic [4:0]  data_addr,
   output logic [31:0] val,
   input  logic [31:0] read_out
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state, state_nxt;

   // Latched request fields (data path, not reset)
   logic        wr_q;
   logic [1:0]  size_q;
   logic        sgn_q;
   logic [6:0]  addr_q;
   logic [31:0] wdata_q;

   logic        rd_en, wr_en;
   logic        req_err;
   logic        accept;

`ifdef LSU_SUBWORD_EN
   // Little-endian lane extraction with optional sign extension
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        sgn);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: r = sgn ? 32'(b) : {24'b0, b};
         SZ_HALF: r = sgn ? 32'(h) : {16'b0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace the addressed lane of the captured word with the store data
   function automatic logic [31:0] store_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
      logic [31:0] r;
      r = old;
      if (size == SZ_BYTE)
         r[{lane, 3'b000} +: 8] = wdata[7:0];
      else if (size == SZ_HALF)
         r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      return r;
   endfunction

   assign req_err = (req_size == 2'b11) ||
                    (req_size == SZ_HALF && req_addr[0]) ||
                    (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
   // Word-only build: every non-word size is rejected
   assign req_err = (req_size != SZ_WORD) || (req_addr[1:0] != 2'b00);

   logic unused_subword;
   assign unused_subword = ^{sgn_q, size_q, addr_q[1:0]};
`endif

   assign accept = (state == IDLE) && req_valid;

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and memory-side controls
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      data_addr = 5'd0;
      val       = 32'd0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_err)
                  state_nxt = RESP;
               else if (!req_write || req_size != SZ_WORD)
                  state_nxt = RD;
               else
                  state_nxt = WR;
            end
         end
         RD: begin
            rd_en     = 1'b1;
            data_addr = addr_q[6:2];
            state_nxt = wr_q ? WR : RESP;
         end
         WR: begin
            wr_en     = 1'b1;
            data_addr = addr_q[6:2];
            val       = wdata_q;
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A reset arriving mid-access must not let the memory see an enable
   assign data_read_flag  = rd_en & ~rst;
   assign data_write_flag = wr_en & ~rst;

   // Capture the request on handshake; fold read data into the store word
   always_ff @(posedge clk) begin
      if (accept) begin
         wr_q    <= req_write;
         size_q  <= req_size;
         sgn_q   <= req_signed;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
`ifdef LSU_SUBWORD_EN
      else if (state == RD && wr_q) begin
         wdata_q <= store_merge(read_out, wdata_q, size_q, addr_q[1:0]);
      end
`endif
   end

   // Response registers, loaded on entry to RESP and held until the next one
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else if (accept && req_err) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b1;
      end else if (state == RD && !wr_q) begin
`ifdef LSU_SUBWORD_EN
         rsp_rdata <= load_extract(read_out, size_q, addr_q[1:0], sgn_q);
`else
         rsp_rdata <= read_out;
`endif
         rsp_err   <= 1'b0;
      end else if (state == WR) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random requests against a reference model
// that tracks memory contents and expected response/latency per request.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [6:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        data_read_flag;
   logic        data_write_flag;
   logic [4:0]  data_addr;
   logic [31:0] val;
   logic [31:0] read_out;

   logic [31:0] mem     [32];
   logic [31:0] ref_mem [32];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .data_read_flag(data_read_flag), .data_write_flag(data_write_flag),
      .data_addr(data_addr), .val(val), .read_out(read_out)
   );

   // Bench-side data memory: combinational read, whole-word write
   assign read_out = mem[data_addr];
   always @(posedge clk) if (data_write_flag) mem[data_addr] <= val;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: expected outcome of one request, updates ref_mem
   task automatic model(input bit w, input bit [1:0] sz, input bit sg,
                        input bit [6:0] a, input bit [31:0] wd,
                        output bit err, output int lat, output bit [31:0] rd,
                        output int nrd, output int nwr, output bit [31:0] wv);
      int unsigned idx, lane, old, b, h, mask;
      idx  = a / 4;
      lane = a % 4;
      old  = ref_mem[idx];
`ifdef LSU_SUBWORD_EN
      err = (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && lane != 0);
`else
      err = (sz != 2) || (lane != 0);
`endif
      rd = 0; wv = 0; nrd = 0; nwr = 0; lat = 1;
      if (err) return;
      if (!w) begin
         lat = 2; nrd = 1;
         if (sz == 2) rd = old;
         else if (sz == 0) begin
            b = (old >> (8 * lane)) & 255;
            if (sg && b > 127) b = b + 32'hFFFFFF00;
            rd = b;
         end else begin
            h = (old >> (16 * (lane / 2))) & 65535;
            if (sg && h > 32767) h = h + 32'hFFFF0000;
            rd = h;
         end
      end else begin
         nwr = 1;
         if (sz == 2) begin
            lat = 2; wv = wd;
         end else begin
            lat = 3; nrd = 1;
            if (sz == 0) begin
               mask = 255 << (8 * lane);
               wv = (old & ~mask) | ((wd & 255) << (8 * lane));
            end else begin
               mask = 65535 << (16 * (lane / 2));
               wv = (old & ~mask) | ((wd & 65535) << (16 * (lane / 2)));
            end
         end
         ref_mem[idx] = wv;
      end
   endtask

   // Issue one request in IDLE and observe the memory side and response
   task automatic do_req(input string tag, input bit w, input bit [1:0] sz,
                         input bit sg, input bit [6:0] a, input bit [31:0] wd);
      bit        e_err;
      int        e_lat, e_nrd, e_nwr;
      bit [31:0] e_rd, e_wv;
      int        lat = 0, nrd = 0, nwr = 0, both = 0;
      logic [4:0]  waddr = 0, raddr = 0;
      logic [31:0] wval = 0, g_rd = 0;
      logic        g_err = 0;
      model(w, sz, sg, a, wd, e_err, e_lat, e_rd, e_nrd, e_nwr, e_wv);
      @(negedge clk);
      check({tag, ".ready"}, {31'b0, req_ready}, 1);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wdata = $urandom;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clk);
         if (data_read_flag && data_write_flag) both++;
         if (data_read_flag) begin nrd++; raddr = data_addr; end
         if (data_write_flag) begin nwr++; waddr = data_addr; wval = val; end
         if (rsp_valid) begin
            lat = cyc; g_rd = rsp_rdata; g_err = rsp_err;
            break;
         end
      end
      if (lat == 0) check({tag, ".timeout"}, 0, 1);
      check({tag, ".lat"}, lat, e_lat);
      check({tag, ".err"}, {31'b0, g_err}, {31'b0, e_err});
      check({tag, ".rdata"}, g_rd, e_rd);
      check({tag, ".nrd"}, nrd, e_nrd);
      check({tag, ".nwr"}, nwr, e_nwr);
      check({tag, ".both"}, both, 0);
      if (e_nrd != 0) check({tag, ".raddr"}, {27'b0, raddr}, a / 4);
      if (e_nwr != 0) begin
         check({tag, ".waddr"}, {27'b0, waddr}, a / 4);
         check({tag, ".wval"}, wval, e_wv);
      end
   endtask

   initial begin
      int quiet;
      for (int i = 0; i < 32; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
      req_signed = 1'b0; req_addr = 7'd0; req_wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.ready", {31'b0, req_ready}, 1);
      check("rst.rsp_valid", {31'b0, rsp_valid}, 0);
      check("rst.rdata", rsp_rdata, 0);
      check("rst.err", {31'b0, rsp_err}, 0);
      check("rst.flags", {30'b0, data_read_flag, data_write_flag}, 0);
      check("rst.addr", {27'b0, data_addr}, 0);
      check("rst.val", val, 0);
      @(negedge clk);
      rst = 1'b0;

      do_req("st_w08", 1, 2'b10, 0, 7'h08, 32'hDEADBEEF);
      do_req("ld_w08", 0, 2'b10, 0, 7'h08, 32'h0);
      check("ld_w08.const", rsp_rdata, 32'hDEADBEEF);
      do_req("st_b09", 1, 2'b00, 0, 7'h09, 32'h0000007F);
`ifdef LSU_SUBWORD_EN
      check("st_b09.mem", mem[2], 32'hDEAD7FEF);
`endif
      do_req("ld_sb0b", 0, 2'b00, 1, 7'h0B, 32'h0);
      do_req("ld_ub0b", 0, 2'b00, 0, 7'h0B, 32'h0);
      do_req("ld_sh0a", 0, 2'b01, 1, 7'h0A, 32'h0);
`ifdef LSU_SUBWORD_EN
      check("ld_sh0a.const", rsp_rdata, 32'hFFFFDEAD);
`endif
      do_req("ld_w05", 0, 2'b10, 0, 7'h05, 32'h0);
      check("ld_w05.errc", {31'b0, rsp_err}, 1);
      do_req("st_h03", 1, 2'b01, 0, 7'h03, 32'h1234);
      do_req("sz11", 0, 2'b11, 0, 7'h00, 32'h0);
      do_req("ld_b00", 0, 2'b00, 0, 7'h00, 32'h0);
      do_req("ld_w00", 0, 2'b10, 0, 7'h00, 32'h0);

      // Reset during the write cycle of a word store
      do_req("ld_w08b", 0, 2'b10, 0, 7'h08, 32'h0);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 7'h10; req_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rstwr.pre", {31'b0, data_write_flag}, 1);
      rst = 1'b1;
      #1;
      check("rstwr.gate", {31'b0, data_write_flag}, 0);
      @(posedge clk);
      #1;
      check("rstwr.ready", {31'b0, req_ready}, 1);
      check("rstwr.rsp_valid", {31'b0, rsp_valid}, 0);
      check("rstwr.rdata", rsp_rdata, 0);
      check("rstwr.err", {31'b0, rsp_err}, 0);
      check("rstwr.flags", {30'b0, data_read_flag, data_write_flag}, 0);
      check("rstwr.addr", {27'b0, data_addr}, 0);
      check("rstwr.val", val, 0);
      @(negedge clk);
      rst = 1'b0;
      check("rstwr.mem", mem[4], ref_mem[4]);
      quiet = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid) quiet++;
      end
      check("rstwr.norsp", quiet, 0);

      // Random traffic, addresses concentrated on a few words
      for (int n = 0; n < 300; n++) begin
         bit [6:0] a;
         a = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 1) == 1) a[6:4] = 3'b000;
         do_req("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), a, $urandom);
      end

      @(negedge clk);
      for (int i = 0; i < 32; i++) check("final.mem", mem[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
